// File: rtl/multi_crop_stream_if.sv
// Pixel stream bundle for multi_crop_stream: raster input stream plus the
// crop-tagged output stream. The engine sits on the slave side.
interface multi_crop_stream_if #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int IW = 1
);
    logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA;
    logic                       pixel_in_TVALID;
    logic                       pixel_in_TREADY;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA;
    logic [IW-1:0]              pixel_out_TUSER;
    logic                       pixel_out_TLAST;
    logic                       pixel_out_TVALID;
    logic                       pixel_out_TREADY;

    modport master (
        output pixel_in_TDATA, pixel_in_TVALID,
        input  pixel_in_TREADY,
        input  pixel_out_TDATA, pixel_out_TUSER, pixel_out_TLAST, pixel_out_TVALID,
        output pixel_out_TREADY
    );

    modport slave (
        input  pixel_in_TDATA, pixel_in_TVALID,
        output pixel_in_TREADY,
        output pixel_out_TDATA, pixel_out_TUSER, pixel_out_TLAST, pixel_out_TVALID,
        input  pixel_out_TREADY
    );
endinterface

// File: rtl/multi_crop_stream.sv
// Streaming multi-window crop: tags each in-window pixel with its crop index and
// end-of-crop marker, buffering results in a first-word-fall-through FIFO.
//
// state | meaning
// IDLE  | waiting for a pixel that falls inside an enabled crop
// EMIT  | pushing the held pixel once per crop in its mask, lowest index first
module multi_crop_stream #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int IN_ROWS = 100,
    parameter int IN_COLS = 160,
    parameter int OUT_ROWS = 48,
    parameter int OUT_COLS = 48,
    parameter int NUM_CROPS = 2,
    parameter int FIFO_DEPTH = 16,
    localparam int RW = $clog2(IN_ROWS),
    localparam int CW = $clog2(IN_COLS),
    localparam int IW = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CROPS*RW-1:0] crop_y_cfg,
    input  logic [NUM_CROPS*CW-1:0] crop_x_cfg,
    multi_crop_stream_if.slave      bus,
    output logic                    cfg_err,
    output logic                    frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = PIXEL_BIT_WIDTH + IW + 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                     state;
    logic [RW-1:0]              row;
    logic [CW-1:0]              col;
    logic [RW-1:0]              lat_y [NUM_CROPS];
    logic [CW-1:0]              lat_x [NUM_CROPS];
    logic [NUM_CROPS-1:0]       lat_en;
    logic [PIXEL_BIT_WIDTH-1:0] hold_pix;
    logic [NUM_CROPS-1:0]       hold_mask;
    logic [RW-1:0]              hold_row;
    logic [CW-1:0]              hold_col;

    logic [DW-1:0]              mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [AW:0]                count;

    logic                       at_origin, accept, push, push_last, pop, full, empty;
    logic                       in_ready, emit_last;
    logic [RW-1:0]              eff_y [NUM_CROPS];
    logic [CW-1:0]              eff_x [NUM_CROPS];
    logic [NUM_CROPS-1:0]       eff_en, in_mask, rest_mask;
    logic [IW-1:0]              sel;

    // At (0,0) the live configuration is used so the first pixel sees the new origins.
    always_comb begin
        at_origin = (row == '0) && (col == '0);
        for (int k = 0; k < NUM_CROPS; k++) begin
            eff_y[k]  = at_origin ? crop_y_cfg[k*RW +: RW] : lat_y[k];
            eff_x[k]  = at_origin ? crop_x_cfg[k*CW +: CW] : lat_x[k];
            eff_en[k] = at_origin ? ((int'(eff_y[k]) + OUT_ROWS <= IN_ROWS) &&
                                     (int'(eff_x[k]) + OUT_COLS <= IN_COLS))
                                  : lat_en[k];
            in_mask[k] = eff_en[k] &&
                         (int'(row) >= int'(eff_y[k])) && (int'(row) < int'(eff_y[k]) + OUT_ROWS) &&
                         (int'(col) >= int'(eff_x[k])) && (int'(col) < int'(eff_x[k]) + OUT_COLS);
        end

        sel = '0;
        for (int k = NUM_CROPS - 1; k >= 0; k--) begin
            if (hold_mask[k]) sel = IW'(k);
        end
        rest_mask      = hold_mask;
        rest_mask[sel] = 1'b0;
        emit_last = (int'(hold_row) == int'(lat_y[sel]) + OUT_ROWS - 1) &&
                    (int'(hold_col) == int'(lat_x[sel]) + OUT_COLS - 1);

        full      = (count == (AW+1)'(FIFO_DEPTH));
        empty     = (count == '0);
        push      = (state == EMIT) && !full;
        push_last = push && (rest_mask == '0);
        in_ready  = !reset && ((state == IDLE) || push_last);
        accept    = bus.pixel_in_TVALID && in_ready;
        pop       = !empty && bus.pixel_out_TREADY;
    end

    assign bus.pixel_in_TREADY  = in_ready;
    assign bus.pixel_out_TVALID = !empty;
    assign {bus.pixel_out_TDATA, bus.pixel_out_TUSER, bus.pixel_out_TLAST} =
        empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {hold_pix, sel, emit_last};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            lat_en     <= '0;
            hold_mask  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cfg_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && (int'(row) == IN_ROWS - 1) && (int'(col) == IN_COLS - 1);

            if (push) begin
                wr_ptr    <= wr_ptr + AW'(1);
                hold_mask <= rest_mask;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);

            if (push_last) state <= IDLE;

            if (accept) begin
                if (int'(col) == IN_COLS - 1) begin
                    col <= '0;
                    row <= (int'(row) == IN_ROWS - 1) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (at_origin) begin
                    lat_y   <= eff_y;
                    lat_x   <= eff_x;
                    lat_en  <= eff_en;
                    cfg_err <= ~&eff_en;
                end
                if (in_mask != '0) begin
                    hold_pix  <= bus.pixel_in_TDATA;
                    hold_mask <= in_mask;
                    hold_row  <= row;
                    hold_col  <= col;
                    state     <= EMIT;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_crop_stream.sv
// Directed bench for multi_crop_stream: per-frame crop tables, FIFO stall,
// latency and mid-frame reset sequences against a raster-window model.
module tb_multi_crop_stream;
    localparam int IN_COLS = 160;
    localparam int WIN = 48;
    localparam int WIN_PIX = WIN * WIN;

    typedef struct {
        int y0, x0, y1, x1;
        int rows, rnd, chg_at, chg_x0, chg_x1;
        int cnt0, cnt1, first0, first1, last0, last1, err, done;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] crop_y_cfg = '0;
    logic [15:0] crop_x_cfg = '0;
    logic        cfg_err, frame_done;

    multi_crop_stream_if #(.PIXEL_BIT_WIDTH(16), .IW(1)) bus ();

    multi_crop_stream dut (
        .clk(clk), .reset(reset),
        .crop_y_cfg(crop_y_cfg), .crop_x_cfg(crop_x_cfg),
        .bus(bus), .cfg_err(cfg_err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int tb_r = 0;
    int tb_c = 0;

    // model state, written by main, read by monitor
    int frame_id = 0;
    int my_y [2];
    int my_x [2];
    int en0 = 1;

    // monitor statistics, written only by the monitor
    int seen_id = -1;
    int out_cnt [2], first_val [2], last_val [2], last_cnt [2], seq_err [2];
    int order_err, done_cnt, prev_user, prev_data;
    int m_k, m_d, m_idx, m_exp;

    always @(negedge clk) begin
        if (frame_id != seen_id) begin
            seen_id = frame_id;
            for (int k = 0; k < 2; k++) begin
                out_cnt[k] = 0; first_val[k] = -1; last_val[k] = -1;
                last_cnt[k] = 0; seq_err[k] = 0;
            end
            order_err = 0; done_cnt = 0; prev_user = -1; prev_data = -1;
        end
        if (frame_done) done_cnt++;
        if (!reset && bus.pixel_out_TVALID && bus.pixel_out_TREADY) begin
            m_k   = int'(bus.pixel_out_TUSER);
            m_d   = int'(bus.pixel_out_TDATA);
            m_idx = out_cnt[m_k];
            m_exp = (my_y[m_k] + m_idx / WIN) * IN_COLS + my_x[m_k] + m_idx % WIN;
            if (m_d != m_exp || bus.pixel_out_TLAST != (m_idx == WIN_PIX - 1)) seq_err[m_k]++;
            if (first_val[m_k] < 0) first_val[m_k] = m_d;
            if (bus.pixel_out_TLAST) begin
                last_cnt[m_k]++;
                last_val[m_k] = m_d;
            end
            // a pixel shared with crop 0 must appear as k=0 immediately followed by k=1
            if (m_k == 1 && en0 != 0 &&
                m_d / IN_COLS >= my_y[0] && m_d / IN_COLS < my_y[0] + WIN &&
                m_d % IN_COLS >= my_x[0] && m_d % IN_COLS < my_x[0] + WIN &&
                !(prev_user == 0 && prev_data == m_d)) order_err++;
            out_cnt[m_k]++;
            prev_user = m_k;
            prev_data = m_d;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic advance();
        tb_c++;
        if (tb_c == IN_COLS) begin
            tb_c = 0;
            tb_r = (tb_r == 99) ? 0 : tb_r + 1;
        end
    endtask

    task automatic feed(input int n, input int rnd, input int chg_at, input int cx0, input int cx1);
        int sent = 0;
        int cyc = 0;
        while (sent < n && cyc < n * 8 + 2000) begin
            bus.pixel_in_TVALID = (rnd != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.pixel_in_TDATA  = 16'(tb_r * IN_COLS + tb_c);
            if (rnd != 0) bus.pixel_out_TREADY = ($urandom_range(0, 1) == 1);
            if (sent == chg_at) crop_x_cfg = {8'(cx1), 8'(cx0)};
            @(negedge clk);
            if (bus.pixel_in_TVALID && bus.pixel_in_TREADY) begin
                sent++;
                advance();
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.pixel_in_TVALID = 1'b0;
        check("feed complete", sent, n);
    endtask

    task automatic drain();
        int quiet = 0;
        int cyc = 0;
        bus.pixel_out_TREADY = 1'b1;
        while (quiet < 4 && cyc < 3000) begin
            @(negedge clk);
            if (bus.pixel_out_TVALID) quiet = 0;
            else quiet++;
            @(posedge clk); #1;
            cyc++;
        end
        check("drain", quiet, 4);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tb_r = 0;
        tb_c = 0;
    endtask

    task automatic start_frame(input vec_t v);
        frame_id++;
        my_y[0] = v.y0; my_x[0] = v.x0;
        my_y[1] = v.y1; my_x[1] = v.x1;
        en0 = (v.cnt0 > 0) ? 1 : 0;
        crop_y_cfg = {7'(v.y1), 7'(v.y0)};
        crop_x_cfg = {8'(v.x1), 8'(v.x0)};
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_stats(input string tag, input vec_t v);
        check({tag, " count0"}, out_cnt[0], v.cnt0);
        check({tag, " count1"}, out_cnt[1], v.cnt1);
        check({tag, " first0"}, first_val[0], v.first0);
        check({tag, " first1"}, first_val[1], v.first1);
        check({tag, " tlast pixel0"}, last_val[0], v.last0);
        check({tag, " tlast pixel1"}, last_val[1], v.last1);
        check({tag, " tlast count0"}, last_cnt[0], (v.cnt0 > 0) ? 1 : 0);
        check({tag, " tlast count1"}, last_cnt[1], (v.cnt1 > 0) ? 1 : 0);
        check({tag, " sequence0 errors"}, seq_err[0], 0);
        check({tag, " sequence1 errors"}, seq_err[1], 0);
        check({tag, " overlap order errors"}, order_err, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        int   accepted, stall, cyc;

        //          y0 x0 y1  x1  rows rnd chg  cx0 cx1  cnt0 cnt1 f0   f1    l0    l1     err done
        vecs[0] = '{10, 10, 30, 40,  78, 0,   -1,   0,   0, 2304, 2304, 1610, 4840, 9177, 12407, 0, 0};
        vecs[1] = '{10, 10, 60, 10, 100, 0,   -1,   0,   0, 2304,    0, 1610,   -1, 9177,    -1, 1, 1};
        vecs[2] = '{ 0,  0, 52, 112,100, 0, 3000,   5, 100, 2304, 2304,    0, 8432, 7567, 15999, 0, 1};
        vecs[3] = '{ 0,  0,  0, 20,  48, 1,   -1,   0,   0, 2304, 2304,    0,   20, 7567,  7587, 0, 0};

        bus.pixel_in_TVALID  = 1'b0;
        bus.pixel_in_TDATA   = '0;
        bus.pixel_out_TREADY = 1'b1;

        // reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("reset in_ready", int'(bus.pixel_in_TREADY), 0);
        check("reset out_valid", int'(bus.pixel_out_TVALID), 0);
        check("reset out_data", int'(bus.pixel_out_TDATA), 0);
        check("reset out_user", int'(bus.pixel_out_TUSER), 0);
        check("reset out_last", int'(bus.pixel_out_TLAST), 0);
        check("reset cfg_err", int'(cfg_err), 0);
        check("reset frame_done", int'(frame_done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready after reset", int'(bus.pixel_in_TREADY), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            start_frame(vecs[i]);
            feed(vecs[i].rows * IN_COLS, vecs[i].rnd, vecs[i].chg_at, vecs[i].chg_x0, vecs[i].chg_x1);
            drain();
            check_stats($sformatf("vec%0d", i), vecs[i]);
            check($sformatf("vec%0d cfg_err", i), int'(cfg_err), vecs[i].err);
            check($sformatf("vec%0d frame_done pulses", i), done_cnt, vecs[i].done);
            if (vecs[i].rows < 100) pulse_reset();
        end

        // output stalled: FIFO fills with 16 entries, one more pixel held, input then blocked
        start_frame(vecs[0]);
        bus.pixel_out_TREADY = 1'b0;
        accepted = 0;
        stall = 0;
        cyc = 0;
        while (stall < 20 && cyc < 4000) begin
            bus.pixel_in_TVALID = 1'b1;
            bus.pixel_in_TDATA  = 16'(tb_r * IN_COLS + tb_c);
            @(negedge clk);
            if (bus.pixel_in_TREADY) begin
                accepted++;
                advance();
                stall = 0;
            end else begin
                stall++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.pixel_in_TVALID = 1'b0;
        check("stall blocked cycles", stall, 20);
        check("stall accepted pixels", accepted, 1627);
        check("stall head data", int'(bus.pixel_out_TDATA), 1610);
        check("stall head user", int'(bus.pixel_out_TUSER), 0);
        check("stall head valid", int'(bus.pixel_out_TVALID), 1);
        bus.pixel_out_TREADY = 1'b1;
        feed(78 * IN_COLS - accepted, 0, -1, 0, 0);
        drain();
        check_stats("after stall", vecs[0]);

        // single-pixel latency, then reset with data in the FIFO
        pulse_reset();
        frame_id++;
        bus.pixel_out_TREADY = 1'b0;
        feed(1611, 0, -1, 10, 40);
        @(negedge clk);
        check("latency before push", int'(bus.pixel_out_TVALID), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("latency after push valid", int'(bus.pixel_out_TVALID), 1);
        check("latency after push data", int'(bus.pixel_out_TDATA), 1610);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid-frame reset in_ready", int'(bus.pixel_in_TREADY), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid-frame reset out_valid", int'(bus.pixel_out_TVALID), 0);
        check("mid-frame reset out_data", int'(bus.pixel_out_TDATA), 0);
        check("mid-frame reset in_ready after", int'(bus.pixel_in_TREADY), 1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
